// File: rtl/mips_harvard_core.sv
// Single-cycle big-endian MIPS-I subset core, Harvard buses, one delay slot.
// Define MIPS_MULTDIV_EN to add HI/LO with MULT/MULTU/MFHI/MFLO/MTHI/MTLO.
module mips_harvard_core #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        active,
   output logic [31:0] register_v0,
   input  logic        clk_enable,
   output logic [31:0] instr_address,
   input  logic [31:0] instr_readdata,
   output logic [31:0] data_address,
   output logic        data_write,
   output logic        data_read,
   output logic [31:0] data_writedata,
   input  logic [31:0] data_readdata
);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_JALR = 6'h09;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;
`ifdef MIPS_MULTDIV_EN
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
`endif

   logic [31:0] pc;
   logic [31:0] npc;
   logic        act;
   logic [31:0] regs [32];

   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] idx;

   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] simm;
   logic [31:0] zimm;
   logic [31:0] pc4;
   logic [31:0] pc8;
   logic [31:0] ea;

   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        br_taken;
   logic [31:0] br_target;
   logic        mem_rd;
   logic        mem_wr;
   logic        mem_ok;

`ifdef MIPS_MULTDIV_EN
   logic [31:0] hi;
   logic [31:0] lo;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] hi_d;
   logic [31:0] lo_d;
   logic [63:0] prod;
`endif

   assign op     = instr_readdata[31:26];
   assign rs     = instr_readdata[25:21];
   assign rt     = instr_readdata[20:16];
   assign rd     = instr_readdata[15:11];
   assign shamt  = instr_readdata[10:6];
   assign funct  = instr_readdata[5:0];
   assign imm    = instr_readdata[15:0];
   assign idx    = instr_readdata[25:0];

   assign rs_val = regs[rs];
   assign rt_val = regs[rt];
   assign simm   = {{16{imm[15]}}, imm};
   assign zimm   = {16'd0, imm};
   assign pc4    = pc + 32'd4;
   assign pc8    = pc + 32'd8;
   assign ea     = rs_val + simm;

   // Decode and execute the current instruction combinationally.
   always_comb begin
      wb_en     = 1'b0;
      wb_addr   = rd;
      wb_data   = 32'd0;
      br_taken  = 1'b0;
      br_target = pc4 + {simm[29:0], 2'b00};
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
`ifdef MIPS_MULTDIV_EN
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      hi_d      = rs_val;
      lo_d      = rs_val;
      prod      = 64'd0;
`endif
      unique case (op)
         OP_SPECIAL: begin
            unique case (funct)
               F_SLL: begin
                  wb_en   = 1'b1;
                  wb_data = rt_val << shamt;
               end
               F_SRL: begin
                  wb_en   = 1'b1;
                  wb_data = rt_val >> shamt;
               end
               F_SRA: begin
                  wb_en   = 1'b1;
                  wb_data = $signed(rt_val) >>> shamt;
               end
               F_JR: begin
                  br_taken  = 1'b1;
                  br_target = rs_val;
               end
               F_JALR: begin
                  br_taken  = 1'b1;
                  br_target = rs_val;
                  wb_en     = 1'b1;
                  wb_data   = pc8;
               end
               F_ADDU: begin
                  wb_en   = 1'b1;
                  wb_data = rs_val + rt_val;
               end
               F_SUBU: begin
                  wb_en   = 1'b1;
                  wb_data = rs_val - rt_val;
               end
               F_AND: begin
                  wb_en   = 1'b1;
                  wb_data = rs_val & rt_val;
               end
               F_OR: begin
                  wb_en   = 1'b1;
                  wb_data = rs_val | rt_val;
               end
               F_XOR: begin
                  wb_en   = 1'b1;
                  wb_data = rs_val ^ rt_val;
               end
               F_SLT: begin
                  wb_en   = 1'b1;
                  wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
               end
               F_SLTU: begin
                  wb_en   = 1'b1;
                  wb_data = {31'd0, rs_val < rt_val};
               end
`ifdef MIPS_MULTDIV_EN
               F_MFHI: begin
                  wb_en   = 1'b1;
                  wb_data = hi;
               end
               F_MFLO: begin
                  wb_en   = 1'b1;
                  wb_data = lo;
               end
               F_MTHI: hi_we = 1'b1;
               F_MTLO: lo_we = 1'b1;
               F_MULT: begin
                  prod  = {{32{rs_val[31]}}, rs_val}
                        * {{32{rt_val[31]}}, rt_val};
                  hi_we = 1'b1;
                  lo_we = 1'b1;
                  hi_d  = prod[63:32];
                  lo_d  = prod[31:0];
               end
               F_MULTU: begin
                  prod  = {32'd0, rs_val} * {32'd0, rt_val};
                  hi_we = 1'b1;
                  lo_we = 1'b1;
                  hi_d  = prod[63:32];
                  lo_d  = prod[31:0];
               end
`endif
               default: ;
            endcase
         end
         OP_J: begin
            br_taken  = 1'b1;
            br_target = {pc4[31:28], idx, 2'b00};
         end
         OP_JAL: begin
            br_taken  = 1'b1;
            br_target = {pc4[31:28], idx, 2'b00};
            wb_en     = 1'b1;
            wb_addr   = 5'd31;
            wb_data   = pc8;
         end
         OP_BEQ: br_taken = (rs_val == rt_val);
         OP_BNE: br_taken = (rs_val != rt_val);
         OP_ADDIU: begin
            wb_en   = 1'b1;
            wb_addr = rt;
            wb_data = rs_val + simm;
         end
         OP_SLTI: begin
            wb_en   = 1'b1;
            wb_addr = rt;
            wb_data = {31'd0, $signed(rs_val) < $signed(simm)};
         end
         OP_SLTIU: begin
            wb_en   = 1'b1;
            wb_addr = rt;
            wb_data = {31'd0, rs_val < simm};
         end
         OP_ANDI: begin
            wb_en   = 1'b1;
            wb_addr = rt;
            wb_data = rs_val & zimm;
         end
         OP_ORI: begin
            wb_en   = 1'b1;
            wb_addr = rt;
            wb_data = rs_val | zimm;
         end
         OP_XORI: begin
            wb_en   = 1'b1;
            wb_addr = rt;
            wb_data = rs_val ^ zimm;
         end
         OP_LUI: begin
            wb_en   = 1'b1;
            wb_addr = rt;
            wb_data = {imm, 16'd0};
         end
         OP_LW: begin
            mem_rd  = 1'b1;
            wb_en   = 1'b1;
            wb_addr = rt;
            wb_data = data_readdata;
         end
         OP_SW: mem_wr = 1'b1;
         default: ;
      endcase
   end

   assign mem_ok         = act & ~reset;
   assign data_write     = mem_wr & mem_ok;
   assign data_read      = mem_rd & mem_ok;
   assign data_address   = ea;
   assign data_writedata = rt_val;
   assign instr_address  = pc;
   assign register_v0    = regs[2];
   assign active         = act;

   // Retire one instruction per enabled edge; halt once PC reaches HALT_ADDR.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc  <= RESET_VECTOR;
         npc <= RESET_VECTOR + 32'd4;
         act <= 1'b1;
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (clk_enable && act) begin
         if (wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
         pc  <= npc;
         npc <= br_taken ? br_target : npc + 32'd4;
         act <= (npc != HALT_ADDR);
      end
   end

`ifdef MIPS_MULTDIV_EN
   // HI/LO update from multiplies and explicit moves.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (clk_enable && act) begin
         if (hi_we) hi <= hi_d;
         if (lo_we) lo <= lo_d;
      end
   end
`endif

endmodule

// File: tb/tb_mips_harvard_core.sv
// Bench for mips_harvard_core: instruction-level reference model,
// directed programs with literal results and random programs.
module tb_mips_harvard_core;

   localparam logic [31:0] RV = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic        active;
   logic [31:0] register_v0;
   logic [31:0] instr_address;
   logic [31:0] instr_readdata;
   logic [31:0] data_address;
   logic        data_write;
   logic        data_read;
   logic [31:0] data_writedata;
   logic [31:0] data_readdata;

   mips_harvard_core dut (
      .clk(clk),
      .reset(reset),
      .active(active),
      .register_v0(register_v0),
      .clk_enable(clk_enable),
      .instr_address(instr_address),
      .instr_readdata(instr_readdata),
      .data_address(data_address),
      .data_write(data_write),
      .data_read(data_read),
      .data_writedata(data_writedata),
      .data_readdata(data_readdata)
   );

   always #5 clk = ~clk;

   logic [31:0] imem [64];
   bit   [31:0] dram [256];
   wire  [31:0] ioff = instr_address - RV;

   assign instr_readdata = (ioff < 32'd256) ? imem[ioff[7:2]] : 32'd0;
   assign data_readdata  = dram[data_address[9:2]];

   int          wr_cnt = 0;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   // External data RAM and store-strobe log.
   always @(posedge clk) begin
      if (clk_enable && data_write) begin
         dram[data_address[9:2]] <= data_writedata;
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= data_address;
         wr_data <= data_writedata;
      end
   end

   // Reference model state
   bit [31:0] m_r [32];
   bit [31:0] m_pc;
   bit [31:0] m_npc;
   bit        m_act;
   bit [31:0] m_dram [256];

   int checks = 0;
   int errors = 0;
   bit started = 0;
   logic [31:0] prog [$];

   function automatic logic [31:0] fetch(input logic [31:0] a);
      logic [31:0] off;
      off = a - RV;
      return (off < 32'd256) ? imem[off[7:2]] : 32'd0;
   endfunction

   function automatic logic [31:0] enc_r(input int rs, input int rt,
                                         input int rd, input int sh,
                                         input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs,
                                         input int rt, input logic [15:0] im);
      return {op, 5'(rs), 5'(rt), im};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit ce);
      logic [31:0] ins, a, b, se, ze, res, tgt, p4;
      logic [5:0] op, fn;
      int rs, rt, rd, sh, dst;
      bit wr, tk;
      if (rst) begin
         m_pc = RV;
         m_npc = RV + 4;
         m_act = 1;
         for (int i = 0; i < 32; i++) m_r[i] = 0;
         return;
      end
      if (!ce || !m_act) return;
      ins = fetch(m_pc);
      op = ins[31:26]; fn = ins[5:0];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
      a = m_r[rs]; b = m_r[rt];
      se = {{16{ins[15]}}, ins[15:0]};
      ze = {16'd0, ins[15:0]};
      p4 = m_pc + 4;
      wr = 0; tk = 0; dst = rt; res = 0; tgt = 0;
      case (op)
         6'h00: begin
            dst = rd; wr = 1;
            case (fn)
               6'h00: res = b << sh;
               6'h02: res = b >> sh;
               6'h03: res = $signed(b) >>> sh;
               6'h08: begin wr = 0; tk = 1; tgt = a; end
               6'h09: begin tk = 1; tgt = a; res = m_pc + 8; end
               6'h21: res = a + b;
               6'h23: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h26: res = a ^ b;
               6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
               6'h2B: res = (a < b) ? 1 : 0;
               default: wr = 0;
            endcase
         end
         6'h02: begin tk = 1; tgt = {p4[31:28], ins[25:0], 2'b00}; end
         6'h03: begin
            tk = 1; tgt = {p4[31:28], ins[25:0], 2'b00};
            wr = 1; dst = 31; res = m_pc + 8;
         end
         6'h04: begin tk = (a == b); tgt = p4 + (se << 2); end
         6'h05: begin tk = (a != b); tgt = p4 + (se << 2); end
         6'h09: begin wr = 1; res = a + se; end
         6'h0A: begin wr = 1; res = ($signed(a) < $signed(se)) ? 1 : 0; end
         6'h0B: begin wr = 1; res = (a < se) ? 1 : 0; end
         6'h0C: begin wr = 1; res = a & ze; end
         6'h0D: begin wr = 1; res = a | ze; end
         6'h0E: begin wr = 1; res = a ^ ze; end
         6'h0F: begin wr = 1; res = {ins[15:0], 16'd0}; end
         6'h23: begin res = a + se; wr = 1; res = m_dram[res[9:2]]; end
         6'h2B: begin res = a + se; m_dram[res[9:2]] = b; end
         default: ;
      endcase
      if (wr && dst != 0) m_r[dst] = res;
      m_pc = m_npc;
      m_npc = tk ? tgt : m_npc + 4;
      m_act = (m_pc != 32'd0);
   endtask

   task automatic compare(input bit rst);
      logic [31:0] ins, ea;
      bit ew, er;
      chk("pc", instr_address, m_pc);
      chk("v0", register_v0, m_r[2]);
      chk("active", {31'd0, active}, {31'd0, m_act});
      ins = fetch(m_pc);
      ea = m_r[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
      ew = m_act && !rst && ins[31:26] == 6'h2B;
      er = m_act && !rst && ins[31:26] == 6'h23;
      chk("data_write", {31'd0, data_write}, {31'd0, ew});
      chk("data_read", {31'd0, data_read}, {31'd0, er});
      if (ew) begin
         chk("sw_addr", data_address, ea);
         chk("sw_data", data_writedata, m_r[ins[20:16]]);
      end
      if (er) chk("lw_addr", data_address, ea);
   endtask

   task automatic cyc(input bit rst, input bit ce);
      reset = rst;
      clk_enable = ce;
      #1;
      if (started) compare(rst);
      model_step(rst, ce);
      started = 1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load();
      for (int i = 0; i < 64; i++)
         imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
   endtask

   task automatic run(input int maxc);
      int n;
      cyc(1, 1);
      n = 0;
      while (m_act && n < maxc) begin
         cyc(0, 1);
         n++;
      end
      #1;
      compare(0);
   endtask

   function automatic logic [31:0] rand_instr(input int pos, input int len);
      logic [5:0] rf [7];
      logic [5:0] iop [7];
      int k, rs, rt, rd, off;
      rf = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B};
      iop = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
      rs = $urandom_range(0, 7);
      rt = $urandom_range(0, 7);
      rd = $urandom_range(0, 7);
      k = $urandom_range(0, 19);
      if (k < 6) return enc_r(rs, rt, rd, 0, rf[$urandom_range(0, 6)]);
      if (k < 8) begin
         logic [5:0] sf [3];
         sf = '{6'h00, 6'h02, 6'h03};
         return enc_r(0, rt, rd, $urandom_range(0, 31), sf[$urandom_range(0, 2)]);
      end
      if (k < 13)
         return enc_i(iop[$urandom_range(0, 6)], rs, rt, 16'($urandom));
      if (k == 13) return enc_i(6'h23, 0, rt, 16'($urandom_range(0, 63) * 4));
      if (k == 14) return enc_i(6'h2B, 0, rt, 16'($urandom_range(0, 63) * 4));
      if (k < 17) begin
         off = $urandom_range(0, 8) - 4;
         if (pos + 1 + off < 0) off = -(pos + 1);
         if (pos + 1 + off > len) off = len - pos - 1;
         return enc_i((k == 15) ? 6'h04 : 6'h05, rs, rt, 16'(off));
      end
      if (k == 17)
         return {6'h03, 26'((RV[27:0] >> 2) + $urandom_range(0, len - 1))};
      if (k == 18)
         return {6'h02, 26'((RV[27:0] >> 2) + $urandom_range(0, len))};
      return {6'h1C, 26'($urandom)};
   endfunction

   task automatic rand_prog();
      prog.delete();
      for (int i = 0; i < 40; i++) prog.push_back(rand_instr(i, 40));
      prog.push_back(32'h00000008);
      prog.push_back(32'h00000000);
      load();
   endtask

   initial begin
      int base;
      reset = 1;
      clk_enable = 1;
      for (int i = 0; i < 64; i++) imem[i] = 32'd0;
      @(negedge clk);

      // reset state
      cyc(1, 1);
      #1;
      chk("rst_pc", instr_address, RV);
      chk("rst_v0", register_v0, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd1);
      chk("rst_dw", {31'd0, data_write}, 32'd0);

      // basic add then halt
      prog = '{enc_i(6'h09, 5, 5, 16'd9), enc_r(5, 5, 2, 0, 6'h21),
               32'h00000008, enc_i(6'h09, 0, 0, 16'd0)};
      load();
      run(20);
      chk("t1_pc", instr_address, 32'd0);
      chk("t1_v0", register_v0, 32'd18);
      chk("t1_active", {31'd0, active}, 32'd0);
      repeat (3) cyc(0, 1);
      chk("t1_frozen_pc", instr_address, 32'd0);
      chk("t1_frozen_v0", register_v0, 32'd18);

      // store then load
      prog = '{enc_i(6'h0F, 0, 3, 16'h1000), enc_i(6'h09, 0, 4, 16'h1234),
               enc_i(6'h2B, 3, 4, 16'd4), enc_i(6'h23, 3, 2, 16'd4),
               32'h00000008, 32'h00000000};
      load();
      base = wr_cnt;
      run(20);
      chk("t2_wr_cnt", 32'(wr_cnt - base), 32'd1);
      chk("t2_wr_addr", wr_addr, 32'h10000004);
      chk("t2_wr_data", wr_data, 32'h00001234);
      chk("t2_v0", register_v0, 32'h00001234);

      // delay slot executes, skipped instruction does not
      prog = '{enc_i(6'h04, 0, 0, 16'd2), enc_i(6'h09, 0, 2, 16'd7),
               enc_i(6'h09, 2, 2, 16'd1), 32'h00000008, 32'h00000000};
      load();
      run(20);
      chk("t3_v0", register_v0, 32'd7);
      chk("t3_active", {31'd0, active}, 32'd0);

      // $0 is hardwired
      prog = '{enc_i(6'h09, 0, 2, 16'd3), enc_i(6'h09, 0, 0, 16'd5),
               enc_r(0, 0, 2, 0, 6'h21), 32'h00000008, 32'h00000000};
      load();
      run(20);
      chk("t4_v0", register_v0, 32'd0);

      // JALR link value and target
      prog = '{enc_i(6'h0F, 0, 6, 16'hBFC0), enc_i(6'h0D, 6, 6, 16'h0018),
               enc_r(6, 0, 2, 0, 6'h09), 32'h00000000,
               enc_i(6'h09, 0, 2, 16'd99), 32'h00000000,
               32'h00000008, 32'h00000000};
      load();
      run(20);
      chk("t5_v0", register_v0, RV + 32'h10);

      // clk_enable stall mid-program
      prog = '{enc_i(6'h09, 0, 2, 16'd1), enc_i(6'h09, 2, 2, 16'd2),
               enc_i(6'h09, 2, 2, 16'd4), enc_i(6'h09, 2, 2, 16'd8),
               32'h00000008, 32'h00000000};
      load();
      cyc(1, 1);
      cyc(0, 1);
      cyc(0, 1);
      repeat (10) cyc(0, 0);
      #1;
      chk("t6_stall_pc", instr_address, RV + 32'd8);
      chk("t6_stall_v0", register_v0, 32'd3);
      while (m_act) cyc(0, 1);
      #1;
      chk("t6_v0", register_v0, 32'd15);
      chk("t6_active", {31'd0, active}, 32'd0);

      // random programs against the model
      for (int p = 0; p < 25; p++) begin
         rand_prog();
         run(300);
      end

      // reset in the middle of a random program
      rand_prog();
      cyc(1, 1);
      repeat (10) cyc(0, 1);
      cyc(1, 1);
      #1;
      chk("t7_pc", instr_address, RV);
      chk("t7_v0", register_v0, 32'd0);
      chk("t7_active", {31'd0, active}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
